// File: rtl/button_pkg.sv
// Shared types and default widths for the button press scheduler.
package button_pkg;

  localparam int unsigned DefHoldW        = 16;
  localparam int unsigned DefGapW         = 16;
  localparam int unsigned DefCntW         = 8;
  localparam int unsigned DefBounceCycles = 4;

  typedef enum logic [2:0] {
    StIdle,
    StBounceIn,
    StHold,
    StBounceOut,
    StGap
  } press_state_t;

  function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; zero_o flags the last cycle of a loaded interval.
module cycle_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/button_press_scheduler.sv
// Command-driven button stimulus: scheduled presses with hold, gap, repeats and bounce.
module button_press_scheduler
  import button_pkg::*;
#(
  parameter int unsigned HOLD_W        = DefHoldW,
  parameter int unsigned GAP_W         = DefGapW,
  parameter int unsigned CNT_W         = DefCntW,
  parameter int unsigned BOUNCE_CYCLES = DefBounceCycles
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [HOLD_W-1:0] cmd_hold_i,
  input  logic [GAP_W-1:0]  cmd_gap_i,
  input  logic [CNT_W-1:0]  cmd_reps_i,
  output logic              btn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  press_count_o
);

  localparam int unsigned TW = max_width(HOLD_W, GAP_W);
  localparam logic [TW-1:0] BounceM1 = (BOUNCE_CYCLES == 0) ? '0 : TW'(BOUNCE_CYCLES - 1);

  press_state_t      state_q, state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [GAP_W-1:0]  gap_q;
  logic [CNT_W-1:0]  reps_q;
  logic [CNT_W-1:0]  press_count_q;
  logic              btn_q, busy_q, done_q, ready_q;

  logic              tmr_load, tmr_zero;
  logic [TW-1:0]     tmr_value;
  logic              start_press, rep_end, finish, accept_zero;
  logic [HOLD_W-1:0] hold_src;
  logic [TW-1:0]     hold_m1, gap_m1;

  // At acceptance the hold value comes straight from the command; afterwards from the latch.
  assign hold_src = (state_q == StIdle) ? cmd_hold_i : hold_q;
  assign hold_m1  = (hold_src == '0) ? '0 : (TW'(hold_src) - TW'(1));
  assign gap_m1   = TW'(gap_q) - TW'(1);

  cycle_timer #(
    .Width (TW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  // Next phase selection and timer reload on every phase entry.
  always_comb begin
    state_d     = state_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    start_press = 1'b0;
    rep_end     = 1'b0;
    finish      = 1'b0;
    accept_zero = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_reps_i == '0) accept_zero = 1'b1;
          else                  start_press = 1'b1;
        end
      end
      StBounceIn: begin
        if (tmr_zero) begin
          state_d   = StHold;
          tmr_load  = 1'b1;
          tmr_value = hold_m1;
        end
      end
      StHold: begin
        if (tmr_zero) begin
          if (BOUNCE_CYCLES != 0) begin
            state_d   = StBounceOut;
            tmr_load  = 1'b1;
            tmr_value = BounceM1;
          end else if (gap_q != '0) begin
            state_d   = StGap;
            tmr_load  = 1'b1;
            tmr_value = gap_m1;
          end else begin
            rep_end = 1'b1;
          end
        end
      end
      StBounceOut: begin
        if (tmr_zero) begin
          if (gap_q != '0) begin
            state_d   = StGap;
            tmr_load  = 1'b1;
            tmr_value = gap_m1;
          end else begin
            rep_end = 1'b1;
          end
        end
      end
      StGap: begin
        if (tmr_zero) rep_end = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (rep_end) begin
      if (reps_q != CNT_W'(1)) begin
        start_press = 1'b1;
      end else begin
        state_d = StIdle;
        finish  = 1'b1;
      end
    end

    if (start_press) begin
      tmr_load = 1'b1;
      if (BOUNCE_CYCLES != 0) begin
        state_d   = StBounceIn;
        tmr_value = BounceM1;
      end else begin
        state_d   = StHold;
        tmr_value = hold_m1;
      end
    end
  end

  // State, latched command, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      gap_q         <= '0;
      reps_q        <= '0;
      press_count_q <= '0;
      btn_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q <= state_d;
      done_q  <= finish | accept_zero;
      busy_q  <= (state_d != StIdle) | accept_zero;
      ready_q <= (state_d == StIdle);

      if (state_q == StIdle && cmd_valid_i) begin
        hold_q <= cmd_hold_i;
        gap_q  <= cmd_gap_i;
        reps_q <= cmd_reps_i;
      end else if (rep_end && reps_q != CNT_W'(1)) begin
        reps_q <= reps_q - 1'b1;
      end

      if (start_press && press_count_q != '1) begin
        press_count_q <= press_count_q + 1'b1;
      end

      if (start_press) begin
        btn_q <= 1'b1;
      end else begin
        case (state_d)
          StBounceIn, StBounceOut: btn_q <= ~btn_q;
          StHold:                  btn_q <= 1'b1;
          default:                 btn_q <= 1'b0;
        endcase
      end
    end
  end

  assign btn_o         = btn_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cmd_ready_o   = ready_q;
  assign press_count_o = press_count_q;

endmodule
